// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared step codes, sequencer state type and flag indices for the control path
package cpu_ctrl_pkg;
  localparam logic [2:0] UOP_FETCH = 3'd0;
  localparam logic [2:0] UOP_DECODE = 3'd1;
  localparam logic [2:0] UOP_IDLE = 3'd7;
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_W = 2;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/instr_counter.sv
// instr_counter: enable-driven wrapping event counter with asynchronous active-low reset
module instr_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) count_q <= '0;
    else if (en_i) count_q <= count_q + 1'b1;
  assign count_o = count_q;
endmodule

// File: rtl/uop_sequencer.sv
// uop_sequencer: uOP step sequencer with flag latch, halt control and retire counter; SINGLE_STEP_EN adds single-step
module uop_sequencer #(
  parameter int UOP_W = 3,
  parameter int MAX_UOP = 6,
  parameter int ICOUNT_W = 16
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                RESET_uOP,
  input  logic                READ_FLAGS,
  input  logic                ALU_ZERO,
  input  logic                ALU_COUT,
  input  logic                HALT,
`ifdef SINGLE_STEP_EN
  input  logic                STEP_REQ,
  output logic                STEP_ACK,
`endif
  output logic [UOP_W-1:0]    uOP,
  output logic                ZERO_FLAG,
  output logic                CIN_FLAG,
  output logic                INSTR_DONE,
  output logic                HALTED,
  output logic                UOP_OVERRUN,
  output logic [ICOUNT_W-1:0] INSTR_COUNT
);
  import cpu_ctrl_pkg::*;
  state_t state_q, state_d;
  logic [UOP_W-1:0] uop_q, uop_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic done_q, ovr_q, ovr_d;
  logic run, retire, last, go;
  assign run = state_q == RUN;
  assign retire = run && RESET_uOP;
  assign last = uop_q == UOP_W'(MAX_UOP);
`ifdef SINGLE_STEP_EN
  logic step_q, step_d, ack_q, ack_d;
  assign go = !HALT || STEP_REQ;
  // remembers that the running instruction was launched by a step request
  assign step_d = run ? step_q && !retire : STEP_REQ;
  assign ack_d = retire && step_q;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      step_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      step_q <= step_d;
      ack_q <= ack_d;
    end
  assign STEP_ACK = ack_q;
`else
  assign go = !HALT;
`endif
  always_comb begin
    state_d = run ? ((retire && HALT) ? IDLE : RUN) : (go ? RUN : IDLE);
    uop_d = (state_d == IDLE) ? UOP_W'(UOP_IDLE) :
            (!run || retire || last) ? UOP_W'(UOP_FETCH) : uop_q + 1'b1;
    ovr_d = run && !RESET_uOP && last;
    flags_d = flags_q;
    if (run && READ_FLAGS) begin
      flags_d[FLAG_ZERO] = ALU_ZERO;
      flags_d[FLAG_CARRY] = ALU_COUT;
    end
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= IDLE;
      uop_q <= UOP_W'(UOP_IDLE);
      flags_q <= '0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      uop_q <= uop_d;
      flags_q <= flags_d;
      done_q <= retire;
      ovr_q <= ovr_d;
    end
  instr_counter #(.W(ICOUNT_W)) u_icount (
    .clk_i(CLK),
    .rst_ni(RESET_N),
    .en_i(retire),
    .count_o(INSTR_COUNT)
  );
  assign uOP = uop_q;
  assign ZERO_FLAG = flags_q[FLAG_ZERO];
  assign CIN_FLAG = flags_q[FLAG_CARRY];
  assign INSTR_DONE = done_q;
  assign UOP_OVERRUN = ovr_q;
  assign HALTED = state_q == IDLE;
endmodule

// File: tb/tb_uop_sequencer.sv
// tb_uop_sequencer: directed self-checking bench for uop_sequencer; step checks run when SINGLE_STEP_EN is defined
module tb_uop_sequencer;
  logic clk = 1'b0;
  logic rst_n, reset_uop, read_flags, alu_zero, alu_cout, halt;
  logic [2:0] uop;
  logic zero_flag, cin_flag, instr_done, halted, uop_overrun;
  logic [15:0] instr_count;
  int n_checks = 0;
  int n_fails = 0;
`ifdef SINGLE_STEP_EN
  logic step_req, step_ack;
`endif
  always #5 clk = ~clk;
  uop_sequencer dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .RESET_uOP(reset_uop),
    .READ_FLAGS(read_flags),
    .ALU_ZERO(alu_zero),
    .ALU_COUT(alu_cout),
    .HALT(halt),
`ifdef SINGLE_STEP_EN
    .STEP_REQ(step_req),
    .STEP_ACK(step_ack),
`endif
    .uOP(uop),
    .ZERO_FLAG(zero_flag),
    .CIN_FLAG(cin_flag),
    .INSTR_DONE(instr_done),
    .HALTED(halted),
    .UOP_OVERRUN(uop_overrun),
    .INSTR_COUNT(instr_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; reset_uop = 1'b0; read_flags = 1'b0;
    alu_zero = 1'b0; alu_cout = 1'b0; halt = 1'b0;
`ifdef SINGLE_STEP_EN
    step_req = 1'b0;
`endif
    #12;
    check("rst_uop", 32'(uop), 32'd7);
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_zero", 32'(zero_flag), 32'd0);
    check("rst_cin", 32'(cin_flag), 32'd0);
    check("rst_done", 32'(instr_done), 32'd0);
    check("rst_ovr", 32'(uop_overrun), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_uop7", 32'(uop), 32'd7);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("seq_uop", 32'(uop), 32'(i));
    end
    check("seq_halted", 32'(halted), 32'd0);
    reset_uop = 1'b1;
    tick();
    reset_uop = 1'b0;
    check("ret_uop", 32'(uop), 32'd0);
    check("ret_done", 32'(instr_done), 32'd1);
    check("ret_count", 32'(instr_count), 32'd1);
    tick();
    check("ret_done_pulse", 32'(instr_done), 32'd0);
    check("ret_uop1", 32'(uop), 32'd1);
    tick(); tick(); tick();
    check("pre_flag_uop", 32'(uop), 32'd4);
    read_flags = 1'b1; alu_zero = 1'b1; alu_cout = 1'b0;
    tick();
    read_flags = 1'b0; alu_zero = 1'b0; alu_cout = 1'b1;
    check("cap_zero", 32'(zero_flag), 32'd1);
    check("cap_cin", 32'(cin_flag), 32'd0);
    reset_uop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_zero", 32'(zero_flag), 32'd1);
      check("hold_cin", 32'(cin_flag), 32'd0);
    end
    reset_uop = 1'b0;
    check("burst_uop", 32'(uop), 32'd0);
    check("burst_count", 32'(instr_count), 32'd11);
    tick(); tick();
    check("halt_pre_uop", 32'(uop), 32'd2);
    halt = 1'b1;
    tick(); tick(); tick();
    check("halt_mid_uop", 32'(uop), 32'd5);
    check("halt_mid_halted", 32'(halted), 32'd0);
    reset_uop = 1'b1;
    tick();
    reset_uop = 1'b0;
    check("halt_uop", 32'(uop), 32'd7);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_done", 32'(instr_done), 32'd1);
    check("halt_count", 32'(instr_count), 32'd12);
    read_flags = 1'b1;
    tick();
    check("idle_uop", 32'(uop), 32'd7);
    check("idle_zero", 32'(zero_flag), 32'd1);
    check("idle_cin", 32'(cin_flag), 32'd0);
    check("idle_done", 32'(instr_done), 32'd0);
    read_flags = 1'b0;
    halt = 1'b0;
    tick();
    check("resume_uop", 32'(uop), 32'd0);
    check("resume_halted", 32'(halted), 32'd0);
    for (int i = 1; i < 7; i++) tick();
    check("ovr_pre_uop", 32'(uop), 32'd6);
    check("ovr_pre_flag", 32'(uop_overrun), 32'd0);
    tick();
    check("ovr_uop", 32'(uop), 32'd0);
    check("ovr_flag", 32'(uop_overrun), 32'd1);
    check("ovr_done", 32'(instr_done), 32'd0);
    check("ovr_count", 32'(instr_count), 32'd12);
    tick();
    check("ovr_pulse", 32'(uop_overrun), 32'd0);
    read_flags = 1'b1; alu_zero = 1'b0; alu_cout = 1'b1;
    reset_uop = 1'b1;
    tick();
    read_flags = 1'b0; reset_uop = 1'b0;
    check("same_uop", 32'(uop), 32'd0);
    check("same_zero", 32'(zero_flag), 32'd0);
    check("same_cin", 32'(cin_flag), 32'd1);
    tick(); tick(); tick();
    check("arst_pre_uop", 32'(uop), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_uop", 32'(uop), 32'd7);
    check("arst_cin", 32'(cin_flag), 32'd0);
    check("arst_count", 32'(instr_count), 32'd0);
    check("arst_halted", 32'(halted), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rerun_uop", 32'(uop), 32'd0);
`ifdef SINGLE_STEP_EN
    halt = 1'b1;
    reset_uop = 1'b1;
    tick();
    reset_uop = 1'b0;
    check("ss_park_uop", 32'(uop), 32'd7);
    check("ss_park_ack", 32'(step_ack), 32'd0);
    tick();
    check("ss_idle_uop", 32'(uop), 32'd7);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("ss_start_uop", 32'(uop), 32'd0);
    tick(); tick(); tick();
    check("ss_step3", 32'(uop), 32'd3);
    reset_uop = 1'b1;
    tick();
    reset_uop = 1'b0;
    check("ss_end_uop", 32'(uop), 32'd7);
    check("ss_ack", 32'(step_ack), 32'd1);
    check("ss_done", 32'(instr_done), 32'd1);
    check("ss_count", 32'(instr_count), 32'd2);
    tick();
    check("ss_ack_pulse", 32'(step_ack), 32'd0);
    check("ss_hold_uop", 32'(uop), 32'd7);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
